// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single-port DataMem between the CPU Memory stage and the GPU
// load/store path. A winner is picked every cycle and its request is muxed
// onto the memory command. Read data comes back one cycle later. The CPU
// Memory stage is stalled whenever it asks for the port and loses.
// All state changes on the falling edge of I_CLOCK.
// I_LOCK is an asynchronous, active-low reset.

module dmem_port_arbiter #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int LINE_ADDR_W = 10,
    parameter int CPU_BURST   = 4
) (
    input  logic                   I_CLOCK,
    input  logic                   I_LOCK,

    input  logic                   I_CPU_Req,
    input  logic                   I_CPU_We,
    input  logic [ADDR_W-1:0]      I_CPU_Addr,
    input  logic [DATA_W-1:0]      I_CPU_WData,
    output logic                   O_CPU_Gnt,
    output logic                   O_CPU_RValid,
    output logic [DATA_W-1:0]      O_CPU_RData,
    output logic                   O_CPUStall,

    input  logic                   I_GPU_Req,
    input  logic                   I_GPU_We,
    input  logic [ADDR_W-1:0]      I_GPU_Addr,
    input  logic [DATA_W-1:0]      I_GPU_WData,
    output logic                   O_GPU_Gnt,
    output logic                   O_GPU_RValid,
    output logic [DATA_W-1:0]      O_GPU_RData,

    output logic                   O_MemEn,
    output logic                   O_MemWe,
    output logic [LINE_ADDR_W-1:0] O_MemAddr,
    output logic [DATA_W-1:0]      O_MemWData,
    input  logic [DATA_W-1:0]      I_MemRData
);

    // The counter must be able to hold the value CPU_BURST itself.
    localparam int STREAK_W = (CPU_BURST < 1) ? 1 : $clog2(CPU_BURST + 1);
    localparam logic [STREAK_W-1:0] BURST_MAX = STREAK_W'(CPU_BURST);

    // Counts consecutive CPU wins taken while the GPU was waiting.
    logic [STREAK_W-1:0] streak_q, streak_d;

    // Registered read responses, one set per requester.
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic              gpu_rvalid_q, gpu_rvalid_d;
    logic [DATA_W-1:0] gpu_rdata_q,  gpu_rdata_d;

    logic cpu_gnt;
    logic gpu_gnt;

    // Pick this cycle's winner. The CPU has priority, but it yields once it
    // has taken CPU_BURST grants in a row while the GPU was waiting. Nothing
    // is granted while the block is held in reset.
    always_comb begin
        cpu_gnt = 1'b0;
        gpu_gnt = 1'b0;
        if (I_LOCK) begin
            if (I_CPU_Req && I_GPU_Req) begin
                if (streak_q == BURST_MAX) begin
                    gpu_gnt = 1'b1;
                end else begin
                    cpu_gnt = 1'b1;
                end
            end else if (I_CPU_Req) begin
                cpu_gnt = 1'b1;
            end else if (I_GPU_Req) begin
                gpu_gnt = 1'b1;
            end
        end
    end

    // Drive the memory command from the winner's request. The byte address
    // becomes a word address by dropping bit 0. The command is all zero when
    // nobody wins.
    always_comb begin
        O_MemEn    = 1'b0;
        O_MemWe    = 1'b0;
        O_MemAddr  = '0;
        O_MemWData = '0;
        if (cpu_gnt) begin
            O_MemEn    = 1'b1;
            O_MemWe    = I_CPU_We;
            O_MemAddr  = I_CPU_Addr[LINE_ADDR_W:1];
            O_MemWData = I_CPU_WData;
        end else if (gpu_gnt) begin
            O_MemEn    = 1'b1;
            O_MemWe    = I_GPU_We;
            O_MemAddr  = I_GPU_Addr[LINE_ADDR_W:1];
            O_MemWData = I_GPU_WData;
        end
    end

    // Drive the grant and stall outputs. The stall is asserted only when the
    // CPU asks for the port and the GPU wins it.
    always_comb begin
        O_CPU_Gnt  = cpu_gnt;
        O_GPU_Gnt  = gpu_gnt;
        O_CPUStall = I_LOCK & I_CPU_Req & ~cpu_gnt;
    end

    // Compute the next streak value. Any GPU win, or a cycle where the GPU is
    // not asking, ends the streak. A CPU win while the GPU waits extends it,
    // saturating at CPU_BURST.
    always_comb begin
        streak_d = streak_q;
        if (!I_GPU_Req || gpu_gnt) begin
            streak_d = '0;
        end else if (cpu_gnt && (streak_q != BURST_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Compute the next read responses. Only the requester that wins a read
    // gets a valid pulse. Read data holds its last value otherwise.
    always_comb begin
        cpu_rvalid_d = cpu_gnt & ~I_CPU_We;
        gpu_rvalid_d = gpu_gnt & ~I_GPU_We;
        cpu_rdata_d  = cpu_rvalid_d ? I_MemRData : cpu_rdata_q;
        gpu_rdata_d  = gpu_rvalid_d ? I_MemRData : gpu_rdata_q;
    end

    // Update state on the falling edge. Reset discards any read in flight.
    always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
        if (!I_LOCK) begin
            streak_q     <= '0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            gpu_rvalid_q <= 1'b0;
            gpu_rdata_q  <= '0;
        end else begin
            streak_q     <= streak_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            gpu_rvalid_q <= gpu_rvalid_d;
            gpu_rdata_q  <= gpu_rdata_d;
        end
    end

    // Drive the response outputs straight from the flops.
    always_comb begin
        O_CPU_RValid = cpu_rvalid_q;
        O_CPU_RData  = cpu_rdata_q;
        O_GPU_RValid = gpu_rvalid_q;
        O_GPU_RData  = gpu_rdata_q;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed-vector bench for dmem_port_arbiter.
// Inputs change just after each falling edge. Outputs are sampled just after
// the rising edge, midway through the cycle. A small DataMem model answers
// reads combinationally and commits writes on the falling edge.

module tb_dmem_port_arbiter;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int LINE_ADDR_W = 10;
    localparam int CPU_BURST   = 4;

    logic                   clock;
    logic                   lock;
    logic                   cpu_req, cpu_we, gpu_req, gpu_we;
    logic [ADDR_W-1:0]      cpu_addr, gpu_addr;
    logic [DATA_W-1:0]      cpu_wdata, gpu_wdata;
    logic                   cpu_gnt, cpu_rvalid, cpu_stall, gpu_gnt, gpu_rvalid;
    logic [DATA_W-1:0]      cpu_rdata, gpu_rdata;
    logic                   mem_en, mem_we;
    logic [LINE_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]      mem_wdata, mem_rdata;

    logic [DATA_W-1:0]      mem [1024];

    int n_vectors = 0;
    int n_miss    = 0;

    typedef struct packed {
        logic        c_gnt;
        logic        g_gnt;
        logic        stall;
        logic        en;
        logic        we;
        logic [9:0]  addr;
        logic [15:0] wd;
        logic        c_rv;
        logic [15:0] c_rd;
        logic        g_rv;
        logic [15:0] g_rd;
    } out_t;

    typedef struct {
        logic        lock;
        logic        c_req;
        logic        c_we;
        logic [15:0] c_addr;
        logic [15:0] c_wd;
        logic        g_req;
        logic        g_we;
        logic [15:0] g_addr;
        logic [15:0] g_wd;
        logic        pulse;
        out_t        exp;
    } vec_t;

    dmem_port_arbiter #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .LINE_ADDR_W (LINE_ADDR_W),
        .CPU_BURST   (CPU_BURST)
    ) dut (
        .I_CLOCK      (clock),
        .I_LOCK       (lock),
        .I_CPU_Req    (cpu_req),
        .I_CPU_We     (cpu_we),
        .I_CPU_Addr   (cpu_addr),
        .I_CPU_WData  (cpu_wdata),
        .O_CPU_Gnt    (cpu_gnt),
        .O_CPU_RValid (cpu_rvalid),
        .O_CPU_RData  (cpu_rdata),
        .O_CPUStall   (cpu_stall),
        .I_GPU_Req    (gpu_req),
        .I_GPU_We     (gpu_we),
        .I_GPU_Addr   (gpu_addr),
        .I_GPU_WData  (gpu_wdata),
        .O_GPU_Gnt    (gpu_gnt),
        .O_GPU_RValid (gpu_rvalid),
        .O_GPU_RData  (gpu_rdata),
        .O_MemEn      (mem_en),
        .O_MemWe      (mem_we),
        .O_MemAddr    (mem_addr),
        .O_MemWData   (mem_wdata),
        .I_MemRData   (mem_rdata)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // DataMem model: combinational read, write committed on the falling edge.
    assign mem_rdata = mem[mem_addr];
    always @(negedge clock) begin
        if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    function automatic out_t mk_out(input logic c_gnt, input logic g_gnt,
                                    input logic stall, input logic en,
                                    input logic we, input logic [9:0] addr,
                                    input logic [15:0] wd, input logic c_rv,
                                    input logic [15:0] c_rd, input logic g_rv,
                                    input logic [15:0] g_rd);
        out_t o;
        o.c_gnt = c_gnt; o.g_gnt = g_gnt; o.stall = stall; o.en = en;
        o.we = we; o.addr = addr; o.wd = wd; o.c_rv = c_rv; o.c_rd = c_rd;
        o.g_rv = g_rv; o.g_rd = g_rd;
        return o;
    endfunction

    function automatic vec_t mk_vec(input logic lk, input logic c_req,
                                    input logic c_we, input logic [15:0] c_addr,
                                    input logic [15:0] c_wd, input logic g_req,
                                    input logic g_we, input logic [15:0] g_addr,
                                    input logic [15:0] g_wd, input logic pulse,
                                    input out_t e);
        vec_t v;
        v.lock = lk; v.c_req = c_req; v.c_we = c_we; v.c_addr = c_addr;
        v.c_wd = c_wd; v.g_req = g_req; v.g_we = g_we; v.g_addr = g_addr;
        v.g_wd = g_wd; v.pulse = pulse; v.exp = e;
        return v;
    endfunction

    // Drive one cycle's inputs just after the falling edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        #1;
        lock      = v.lock;
        cpu_req   = v.c_req;
        cpu_we    = v.c_we;
        cpu_addr  = v.c_addr;
        cpu_wdata = v.c_wd;
        gpu_req   = v.g_req;
        gpu_we    = v.g_we;
        gpu_addr  = v.g_addr;
        gpu_wdata = v.g_wd;
    endtask

    // Sample mid-cycle and compare against the vector; optionally start a
    // reset pulse that spans the next falling edge.
    task automatic checkOutput(input vec_t v, input string name);
        out_t act;
        @(posedge clock);
        #1;
        act.c_gnt = cpu_gnt;   act.g_gnt = gpu_gnt;   act.stall = cpu_stall;
        act.en    = mem_en;    act.we    = mem_we;    act.addr  = mem_addr;
        act.wd    = mem_wdata; act.c_rv  = cpu_rvalid; act.c_rd = cpu_rdata;
        act.g_rv  = gpu_rvalid; act.g_rd = gpu_rdata;
        n_vectors++;
        if (act !== v.exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got cg=%0b gg=%0b st=%0b en=%0b we=%0b a=%h wd=%h crv=%0b crd=%h grv=%0b grd=%h, want cg=%0b gg=%0b st=%0b en=%0b we=%0b a=%h wd=%h crv=%0b crd=%h grv=%0b grd=%h",
                     name, act.c_gnt, act.g_gnt, act.stall, act.en, act.we,
                     act.addr, act.wd, act.c_rv, act.c_rd, act.g_rv, act.g_rd,
                     v.exp.c_gnt, v.exp.g_gnt, v.exp.stall, v.exp.en, v.exp.we,
                     v.exp.addr, v.exp.wd, v.exp.c_rv, v.exp.c_rd, v.exp.g_rv,
                     v.exp.g_rd);
        end
        if (v.pulse) begin
            #1;
            lock = 1'b0;
        end
    endtask

    task automatic runVec(input vec_t v, input string name);
        applyStimulus(v);
        checkOutput(v, name);
    endtask

    vec_t tbl [9];
    vec_t rst_tbl [10];

    initial begin
        lock = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        gpu_req = 1'b0; gpu_we = 1'b0; gpu_addr = '0; gpu_wdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'h008] = 16'h1234;
        mem[10'h020] = 16'h2020;
        for (int i = 0; i < 8; i++) mem[10'h100 + i] = 16'(16'h1000 + i);

        // Reset with both requesting, then single-cycle functional vectors.
        tbl[0] = mk_vec(0, 1,0,16'h0010,16'h0000, 1,0,16'h0040,16'h0000, 0,
                        mk_out(0,0,0,0,0,10'h000,16'h0000, 0,16'h0000, 0,16'h0000));
        tbl[1] = mk_vec(1, 1,0,16'h0010,16'h0000, 1,0,16'h0040,16'h0000, 0,
                        mk_out(1,0,0,1,0,10'h008,16'h0000, 0,16'h0000, 0,16'h0000));
        tbl[2] = mk_vec(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,
                        mk_out(0,0,0,0,0,10'h000,16'h0000, 1,16'h1234, 0,16'h0000));
        tbl[3] = mk_vec(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,
                        mk_out(0,0,0,0,0,10'h000,16'h0000, 0,16'h1234, 0,16'h0000));
        tbl[4] = mk_vec(1, 0,0,16'h0000,16'h0000, 1,1,16'h07FE,16'hBEEF, 0,
                        mk_out(0,1,0,1,1,10'h3FF,16'hBEEF, 0,16'h1234, 0,16'h0000));
        tbl[5] = mk_vec(1, 1,0,16'h07FF,16'h0000, 0,0,16'h0000,16'h0000, 0,
                        mk_out(1,0,0,1,0,10'h3FF,16'h0000, 0,16'h1234, 0,16'h0000));
        tbl[6] = mk_vec(1, 1,1,16'h0042,16'h7777, 0,0,16'h0000,16'h0000, 0,
                        mk_out(1,0,0,1,1,10'h021,16'h7777, 1,16'hBEEF, 0,16'h0000));
        tbl[7] = mk_vec(1, 0,0,16'h0000,16'h0000, 1,0,16'h0042,16'h0000, 0,
                        mk_out(0,1,0,1,0,10'h021,16'h0000, 0,16'hBEEF, 0,16'h0000));
        tbl[8] = mk_vec(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,
                        mk_out(0,0,0,0,0,10'h000,16'h0000, 0,16'hBEEF, 1,16'h7777));

        // Reset during contention and during a CPU read in flight.
        rst_tbl[0] = mk_vec(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,
                            mk_out(0,0,0,0,0,10'h000,16'h0000, 1,16'h1234, 0,16'h2020));
        for (int i = 1; i <= 4; i++) begin
            rst_tbl[i] = mk_vec(1, 1,0,16'h0010,16'h0000, 1,0,16'h0040,16'h0000, 0,
                                mk_out(1,0,0,1,0,10'h008,16'h0000,
                                       logic'(i > 1),16'h1234, 0,16'h2020));
        end
        rst_tbl[5] = mk_vec(1, 1,0,16'h0010,16'h0000, 1,0,16'h0040,16'h0000, 1,
                            mk_out(0,1,1,1,0,10'h020,16'h0000, 1,16'h1234, 0,16'h2020));
        rst_tbl[6] = mk_vec(0, 1,0,16'h0010,16'h0000, 1,0,16'h0040,16'h0000, 0,
                            mk_out(0,0,0,0,0,10'h000,16'h0000, 0,16'h0000, 0,16'h0000));
        rst_tbl[7] = mk_vec(1, 1,0,16'h0010,16'h0000, 1,0,16'h0040,16'h0000, 1,
                            mk_out(1,0,0,1,0,10'h008,16'h0000, 0,16'h0000, 0,16'h0000));
        rst_tbl[8] = mk_vec(0, 1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 0,
                            mk_out(0,0,0,0,0,10'h000,16'h0000, 0,16'h0000, 0,16'h0000));
        rst_tbl[9] = mk_vec(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,
                            mk_out(0,0,0,0,0,10'h000,16'h0000, 0,16'h0000, 0,16'h0000));

        for (int i = 0; i < 9; i++) begin
            runVec(tbl[i], $sformatf("basic[%0d]", i));
        end

        // GPU streams reads alone: a grant every cycle, valid one cycle later.
        for (int k = 0; k < 9; k++) begin
            vec_t v;
            logic act_k;
            act_k = logic'(k < 8);
            v = mk_vec(1, 0,0,16'h0000,16'h0000,
                       act_k,0, act_k ? 16'(16'h0200 + 2*k) : 16'h0000,16'h0000, 0,
                       mk_out(0,act_k,0,act_k,0, act_k ? 10'(10'h100 + k) : 10'h000,
                              16'h0000, 0,16'hBEEF, logic'(k >= 1),
                              (k >= 1) ? 16'(16'h1000 + k - 1) : 16'h7777));
            runVec(v, $sformatf("gpu_stream[%0d]", k));
        end

        // Both requesting continuously: C,C,C,C,G repeating.
        for (int k = 0; k < 11; k++) begin
            vec_t v;
            logic g_win, prev_g;
            g_win  = logic'((k % 5) == 4);
            prev_g = logic'((k % 5) == 0);
            v = mk_vec(1, 1,0,16'h0010,16'h0000, 1,0,16'h0040,16'h0000, 0,
                       mk_out(~g_win, g_win, g_win, 1, 0,
                              g_win ? 10'h020 : 10'h008, 16'h0000,
                              logic'(k > 0) & ~prev_g, (k >= 1) ? 16'h1234 : 16'hBEEF,
                              logic'(k > 0) & prev_g,  (k >= 5) ? 16'h2020 : 16'h1007));
            runVec(v, $sformatf("burst[%0d]", k));
        end

        for (int i = 0; i < 10; i++) begin
            runVec(rst_tbl[i], $sformatf("reset_seq[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miss);
        $finish;
    end

endmodule
